// File: rtl/scale_measurement_capture.sv
// Acquisition front-end: waits for stable scale readings, averages a fixed window,
// and holds one weight/height pair behind a valid/ready handshake.
module scale_measurement_capture #(
    parameter int unsigned STABLE_N   = 4,
    parameter int unsigned TOL        = 2,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned MIN_WEIGHT = 10,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sample_valid,
    input  logic [8:0] raw_weight,
    input  logic [7:0] raw_height,
    input  logic       meas_ready,
    output logic [8:0] weight,
    output logic [7:0] height,
    output logic       meas_valid,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] ACCUM  = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam int unsigned SW         = 9 + AVG_LOG2;
    localparam int unsigned SH         = 8 + AVG_LOG2;
    localparam int unsigned ACC_LAST_I = (1 << AVG_LOG2) - 1;

    localparam logic [AVG_LOG2:0] ACC_LAST  = ACC_LAST_I[AVG_LOG2:0];
    localparam logic [8:0]        MIN_W     = MIN_WEIGHT[8:0];
    localparam logic [9:0]        TOL_W     = TOL[9:0];
    localparam logic [8:0]        TOL_H     = TOL[8:0];
    localparam logic [3:0]        STABLE_W  = STABLE_N[3:0];
    localparam logic [7:0]        TIMEOUT_W = TIMEOUT[7:0];

    logic [1:0]          state_q, state_d;
    logic [3:0]          stable_cnt_q, stable_cnt_d;
    logic [7:0]          sample_cnt_q, sample_cnt_d;
    logic [AVG_LOG2:0]   acc_cnt_q, acc_cnt_d;
    logic [SW-1:0]       sum_w_q, sum_w_d;
    logic [SH-1:0]       sum_h_q, sum_h_d;
    logic [8:0]          prev_w_q, prev_w_d;
    logic [7:0]          prev_h_q, prev_h_d;
    logic [8:0]          weight_q, weight_d;
    logic [7:0]          height_q, height_d;
    logic                meas_valid_q, meas_valid_d;
    logic                timeout_q, timeout_d;

    logic [9:0]          diff_w;
    logic [8:0]          diff_h;
    logic                in_tol;
    logic                below_min;
    logic [7:0]          sample_cnt_inc;
    logic [3:0]          stable_next;
    logic [SW-1:0]       total_w;
    logic [SH-1:0]       total_h;

    always_comb begin
        diff_w = (raw_weight >= prev_w_q) ? ({1'b0, raw_weight} - {1'b0, prev_w_q})
                                          : ({1'b0, prev_w_q} - {1'b0, raw_weight});
        diff_h = (raw_height >= prev_h_q) ? ({1'b0, raw_height} - {1'b0, prev_h_q})
                                          : ({1'b0, prev_h_q} - {1'b0, raw_height});
        in_tol         = (diff_w <= TOL_W) && (diff_h <= TOL_H);
        below_min      = (raw_weight < MIN_W);
        sample_cnt_inc = sample_cnt_q + 8'd1;
        total_w        = sum_w_q + SW'(raw_weight);
        total_h        = sum_h_q + SH'(raw_height);
        // sample_cnt_q == 0 marks the first sample since start: no valid prev yet
        if (below_min) begin
            stable_next = 4'd0;
        end else if ((sample_cnt_q == 8'd0) || !in_tol) begin
            stable_next = 4'd1;
        end else begin
            stable_next = stable_cnt_q + 4'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        sample_cnt_d = sample_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        sum_w_d      = sum_w_q;
        sum_h_d      = sum_h_q;
        prev_w_d     = prev_w_q;
        prev_h_d     = prev_h_q;
        weight_d     = weight_q;
        height_d     = height_q;
        meas_valid_d = meas_valid_q;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SETTLE;
                    stable_cnt_d = '0;
                    sample_cnt_d = '0;
                    acc_cnt_d    = '0;
                    sum_w_d      = '0;
                    sum_h_d      = '0;
                end
            end
            SETTLE: begin
                if (sample_valid) begin
                    sample_cnt_d = sample_cnt_inc;
                    prev_w_d     = raw_weight;
                    prev_h_d     = raw_height;
                    stable_cnt_d = stable_next;
                    if (sample_cnt_inc == TIMEOUT_W) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else if (stable_next == STABLE_W) begin
                        state_d   = ACCUM;
                        acc_cnt_d = '0;
                        sum_w_d   = '0;
                        sum_h_d   = '0;
                    end
                end
            end
            ACCUM: begin
                if (sample_valid) begin
                    sample_cnt_d = sample_cnt_inc;
                    prev_w_d     = raw_weight;
                    prev_h_d     = raw_height;
                    if (in_tol && !below_min && (acc_cnt_q == ACC_LAST)) begin
                        // Completion outranks a timeout on the same sample
                        weight_d     = total_w[SW-1:AVG_LOG2];
                        height_d     = total_h[SH-1:AVG_LOG2];
                        meas_valid_d = 1'b1;
                        state_d      = HOLD;
                    end else begin
                        if (in_tol && !below_min) begin
                            sum_w_d   = total_w;
                            sum_h_d   = total_h;
                            acc_cnt_d = acc_cnt_q + 1'b1;
                        end else begin
                            state_d      = SETTLE;
                            stable_cnt_d = below_min ? 4'd0 : 4'd1;
                            acc_cnt_d    = '0;
                            sum_w_d      = '0;
                            sum_h_d      = '0;
                        end
                        if (sample_cnt_inc == TIMEOUT_W) begin
                            timeout_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            HOLD: begin
                if (meas_ready) begin
                    meas_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            stable_cnt_q <= '0;
            sample_cnt_q <= '0;
            acc_cnt_q    <= '0;
            sum_w_q      <= '0;
            sum_h_q      <= '0;
            prev_w_q     <= '0;
            prev_h_q     <= '0;
            weight_q     <= '0;
            height_q     <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            sum_w_q      <= sum_w_d;
            sum_h_q      <= sum_h_d;
            prev_w_q     <= prev_w_d;
            prev_h_q     <= prev_h_d;
            weight_q     <= weight_d;
            height_q     <= height_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign weight      = weight_q;
    assign height      = height_q;
    assign meas_valid  = meas_valid_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_scale_measurement_capture.sv
// Bench for scale_measurement_capture: directed scenarios followed by randomized
// sample streams, compared each cycle against a queue-based reference model.
module tb_scale_measurement_capture;

    localparam int STABLE_N   = 4;
    localparam int TOL        = 2;
    localparam int AVG_LOG2   = 2;
    localparam int MIN_WEIGHT = 10;
    localparam int TIMEOUT    = 64;
    localparam int WIN        = 1 << AVG_LOG2;

    localparam int P_IDLE   = 0;
    localparam int P_SETTLE = 1;
    localparam int P_ACCUM  = 2;
    localparam int P_HOLD   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sample_valid = 1'b0;
    logic [8:0] raw_weight = '0;
    logic [7:0] raw_height = '0;
    logic       meas_ready = 1'b0;
    logic [8:0] weight;
    logic [7:0] height;
    logic       meas_valid;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    int m_phase, m_cnt, m_run, m_pw, m_ph, m_w, m_h;
    bit m_have_prev, m_valid, m_tout;
    int qw[$];
    int qh[$];

    scale_measurement_capture #(
        .STABLE_N  (STABLE_N),
        .TOL       (TOL),
        .AVG_LOG2  (AVG_LOG2),
        .MIN_WEIGHT(MIN_WEIGHT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sample_valid(sample_valid),
        .raw_weight  (raw_weight),
        .raw_height  (raw_height),
        .meas_ready  (meas_ready),
        .weight      (weight),
        .height      (height),
        .meas_valid  (meas_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_cnt = 0; m_run = 0; m_pw = 0; m_ph = 0;
        m_w = 0; m_h = 0; m_have_prev = 0; m_valid = 0; m_tout = 0;
        qw.delete(); qh.delete();
    endtask

    // One clock edge of the measurement rules, in terms of runs and a sample window
    task automatic model_update(input bit st, input bit sv, input int w, input int h, input bit rdy);
        bit ok;
        int sw, sh;
        m_tout = 0;
        case (m_phase)
            P_IDLE: if (st) begin
                m_phase = P_SETTLE; m_cnt = 0; m_run = 0; m_have_prev = 0;
                qw.delete(); qh.delete();
            end
            P_SETTLE: if (sv) begin
                m_cnt++;
                ok = m_have_prev && iabs(w - m_pw) <= TOL && iabs(h - m_ph) <= TOL;
                if (w < MIN_WEIGHT) m_run = 0;
                else if (!ok) m_run = 1;
                else m_run++;
                m_pw = w; m_ph = h; m_have_prev = 1;
                if (m_cnt == TIMEOUT) begin
                    m_tout = 1; m_phase = P_IDLE;
                end else if (m_run == STABLE_N) begin
                    m_phase = P_ACCUM; qw.delete(); qh.delete();
                end
            end
            P_ACCUM: if (sv) begin
                m_cnt++;
                ok = iabs(w - m_pw) <= TOL && iabs(h - m_ph) <= TOL && w >= MIN_WEIGHT;
                m_pw = w; m_ph = h;
                if (ok) begin
                    qw.push_back(w); qh.push_back(h);
                    if (qw.size() == WIN) begin
                        sw = 0; sh = 0;
                        foreach (qw[i]) begin sw += qw[i]; sh += qh[i]; end
                        m_w = sw / WIN; m_h = sh / WIN; m_valid = 1; m_phase = P_HOLD;
                    end
                end else begin
                    m_phase = P_SETTLE; m_run = (w < MIN_WEIGHT) ? 0 : 1;
                    qw.delete(); qh.delete();
                end
                if (m_phase != P_HOLD && m_cnt == TIMEOUT) begin
                    m_tout = 1; m_phase = P_IDLE;
                end
            end
            P_HOLD: if (rdy) begin
                m_valid = 0; m_phase = P_IDLE;
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".weight"}, weight, m_w);
        chk({tag, ".height"}, height, m_h);
        chk({tag, ".meas_valid"}, meas_valid, m_valid);
        chk({tag, ".busy"}, busy, (m_phase != P_IDLE));
        chk({tag, ".timeout_err"}, timeout_err, m_tout);
    endtask

    task automatic step(input string tag, input bit st, input bit sv, input int w, input int h, input bit rdy);
        start = st; sample_valid = sv; meas_ready = rdy;
        raw_weight = w[8:0]; raw_height = h[7:0];
        @(posedge clk);
        model_update(st, sv, w, h, rdy);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        int seq_a[8]  = '{70, 71, 70, 72, 70, 71, 71, 72};
        int seq_b[10] = '{70, 71, 80, 80, 80, 80, 80, 80, 80, 80};
        int seq_c[14] = '{70, 70, 70, 70, 70, 70, 75, 75, 75, 75, 75, 75, 75, 75};
        int seq_d[8]  = '{101, 102, 101, 102, 100, 101, 102, 103};
        int tcount;
        int base_w, base_h, w, h;
        bit st, sv, rdy;

        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Basic measurement
        step("s1_start", 1, 0, 0, 0, 0);
        foreach (seq_a[i]) step("s1", 0, 1, seq_a[i], 175, 0);
        chk("s1_valid", meas_valid, 1);
        chk("s1_weight", weight, 71);
        chk("s1_height", height, 175);
        step("s1_ready", 0, 0, 0, 0, 1);
        chk("s1_valid_drop", meas_valid, 0);
        chk("s1_busy_drop", busy, 0);

        // Settling restart
        step("s2_start", 1, 0, 0, 0, 0);
        foreach (seq_b[i]) step("s2", 0, 1, seq_b[i], 170, 0);
        chk("s2_weight", weight, 80);
        chk("s2_valid", meas_valid, 1);
        step("s2_ready", 0, 0, 0, 0, 1);

        // Break during accumulation
        step("s3_start", 1, 0, 0, 0, 0);
        foreach (seq_c[i]) begin
            step("s3", 0, 1, seq_c[i], 160, 0);
            if (i == 6) chk("s3_break_no_valid", meas_valid, 0);
        end
        chk("s3_weight", weight, 75);
        chk("s3_height", height, 160);
        step("s3_ready", 0, 0, 0, 0, 1);

        // Empty platform until timeout
        tcount = 0;
        step("s4_start", 1, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) begin
            step("s4", 0, 1, 5, 100, 0);
            if (timeout_err === 1'b1) tcount++;
            if (i == 19) chk("s4_no_valid", meas_valid, 0);
        end
        chk("s4_timeout_pulses", tcount, 1);
        chk("s4_busy", busy, 0);
        step("s4_after", 0, 1, 5, 100, 0);
        chk("s4_pulse_gone", timeout_err, 0);

        // Backpressure: HOLD ignores start and samples
        step("s5_start", 1, 0, 0, 0, 0);
        foreach (seq_a[i]) step("s5", 0, 1, seq_a[i], 175, 0);
        for (int i = 0; i < 10; i++) begin
            step("s5_hold", 1, 1, 200, 200, 0);
            chk("s5_hold_valid", meas_valid, 1);
            chk("s5_hold_weight", weight, 71);
            chk("s5_hold_height", height, 175);
        end
        step("s5_ready_start", 1, 0, 0, 0, 1);
        chk("s5_valid_drop", meas_valid, 0);
        step("s5_idle", 0, 0, 0, 0, 0);
        chk("s5_start_ignored", busy, 0);
        chk("s5_weight_kept", weight, 71);

        // Reset in the middle of accumulation
        step("s6_start", 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("s6", 0, 1, 90, 150, 0);
        start = 0; sample_valid = 0; meas_ready = 0; raw_weight = '0; raw_height = '0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("s6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("s6_restart", 1, 0, 0, 0, 0);
        foreach (seq_d[i]) step("s6_full", 0, 1, seq_d[i], 180, 0);
        chk("s6_weight", weight, 101);
        chk("s6_height", height, 180);
        step("s6_ready", 0, 0, 0, 0, 1);

        // Randomized streams
        base_w = 100; base_h = 170;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) base_w = int'($urandom_range(0, 500));
            if ($urandom_range(0, 15) == 0) base_h = int'($urandom_range(0, 250));
            w = base_w + int'($urandom_range(0, 3));
            h = base_h + int'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) w = int'($urandom_range(0, 9));
            st  = ($urandom_range(0, 9) == 0);
            sv  = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 3) == 0);
            step("rand", st, sv, w, h, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
